// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the shift sequencer and the shift-amount mux owner
package shift_pkg;

   localparam int AMT_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SHIFT  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      CTRL_NOP   = 3'b000,
      CTRL_LOAD  = 3'b001,
      CTRL_SHL1  = 3'b010,
      CTRL_SHRL1 = 3'b011,
      CTRL_SHRA1 = 3'b100
   } shift_ctrl_e;

   typedef enum logic [1:0] {
      OP_SLL     = 2'b00,
      OP_SRL     = 2'b01,
      OP_SRA     = 2'b10,
      OP_ILLEGAL = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      SRC_INSTR = 2'b00,
      SRC_REGB  = 2'b01,
      SRC_C16   = 2'b10,
      SRC_MDR   = 2'b11
   } shift_src_e;

   // One-bit shift-register command for each legal shift kind
   function automatic shift_ctrl_e op_to_ctrl(input shift_op_e op);
      shift_ctrl_e ctrl;
      case (op)
         OP_SLL:  ctrl = CTRL_SHL1;
         OP_SRL:  ctrl = CTRL_SHRL1;
         OP_SRA:  ctrl = CTRL_SHRA1;
         default: ctrl = CTRL_NOP;
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/shift_counter.sv
// rtl/shift_counter.sv - loadable down-counter tracking remaining one-bit shifts
module shift_counter
   import shift_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [AMT_W-1:0] load_value,
   input  logic             dec,
   output logic [AMT_W-1:0] value,
   output logic             is_one
);

   logic [AMT_W-1:0] cnt_q;
   logic [AMT_W-1:0] cnt_d;

   // Saturate at zero so a stray decrement can never wrap to 31
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_value;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value  = cnt_q;
   assign is_one = (cnt_q == AMT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences amount select, load and N one-bit shifts, then pulses done
module shift_sequencer
   import shift_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [1:0]       src,
   input  logic [AMT_W-1:0] sa_in,
   output logic [1:0]       sa_sel,
   output logic [2:0]       shift_ctrl,
   output logic [AMT_W-1:0] shift_amt,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_e           state_q, state_d;
   shift_op_e        op_q, op_d;
   logic [1:0]       src_q, src_d;
   logic [AMT_W-1:0] amt_q, amt_d;
   logic             err_q, err_d;

   logic             cnt_load;
   logic             cnt_dec;
   logic [AMT_W-1:0] cnt_value;
   logic             cnt_is_one;
   shift_ctrl_e      ctrl;

   shift_counter u_counter (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (cnt_load),
      .load_value (amt_q),
      .dec        (cnt_dec),
      .value      (cnt_value),
      .is_one     (cnt_is_one)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      src_d    = src_q;
      amt_d    = amt_q;
      err_d    = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      sa_sel   = 2'b00;
      ctrl     = CTRL_NOP;
      busy     = 1'b1;
      done     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (op == OP_ILLEGAL) begin
                  err_d = 1'b1;
               end else begin
                  op_d    = shift_op_e'(op);
                  src_d   = src;
                  state_d = ST_SELECT;
               end
            end
         end
         ST_SELECT: begin
            sa_sel  = src_q;
            amt_d   = sa_in;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            sa_sel   = src_q;
            ctrl     = CTRL_LOAD;
            cnt_load = 1'b1;
            // A zero amount skips SHIFT so the counter is never decremented at 0
            state_d  = (amt_q != '0) ? ST_SHIFT : ST_DONE;
         end
         ST_SHIFT: begin
            ctrl    = op_to_ctrl(op_q);
            cnt_dec = (cnt_value != '0);
            if (cnt_is_one) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            busy    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_SLL;
         src_q   <= 2'b00;
         amt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         src_q   <= src_d;
         amt_q   <= amt_d;
         err_q   <= err_d;
      end
   end

   assign shift_ctrl = ctrl;
   assign shift_amt  = amt_q;
   assign err        = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized and directed bench against a cycle-offset reference model
module tb_shift_sequencer;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [1:0] op;
   logic [1:0] src;
   logic [4:0] sa_in;
   logic [1:0] sa_sel;
   logic [2:0] shift_ctrl;
   logic [4:0] shift_amt;
   logic       busy;
   logic       done;
   logic       err;

   int n_checks;
   int n_fails;

   // Reference model: one transaction described by its start cycle and amount
   int         cur;
   int         ks;
   int         m_n;
   int         err_at;
   logic       active;
   logic [1:0] m_op;
   logic [1:0] m_src;
   int         exp_amt;

   shift_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .op         (op),
      .src        (src),
      .sa_in      (sa_in),
      .sa_sel     (sa_sel),
      .shift_ctrl (shift_ctrl),
      .shift_amt  (shift_amt),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int expv);
      n_checks++;
      if (got !== expv) begin
         n_fails++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cur, got, expv);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_sa_sel"}, int'(sa_sel), 0);
      check_eq({tag, "_ctrl"}, int'(shift_ctrl), 0);
      check_eq({tag, "_amt"}, int'(shift_amt), 0);
      check_eq({tag, "_busy"}, int'(busy), 0);
      check_eq({tag, "_done"}, int'(done), 0);
      check_eq({tag, "_err"}, int'(err), 0);
   endtask

   task automatic step(input logic s, input logic [1:0] o, input logic [1:0] sr, input logic [4:0] sa);
      int  d;
      int  e_sel, e_ctrl, e_busy, e_done, e_err;
      logic busy_now;
      @(negedge clk);
      e_sel = 0; e_ctrl = 0; e_busy = 0; e_done = 0;
      if (active) begin
         d = cur - ks;
         if (d == 1) begin
            e_busy = 1; e_sel = int'(m_src);
         end else if (d == 2) begin
            e_busy = 1; e_sel = int'(m_src); e_ctrl = 1;
         end else if (d <= 2 + m_n) begin
            e_busy = 1; e_ctrl = int'(m_op) + 2;
         end else if (d == 3 + m_n) begin
            e_busy = 1; e_done = 1;
         end
      end
      e_err = (cur == err_at) ? 1 : 0;
      check_eq("sa_sel", int'(sa_sel), e_sel);
      check_eq("shift_ctrl", int'(shift_ctrl), e_ctrl);
      check_eq("shift_amt", int'(shift_amt), exp_amt);
      check_eq("busy", int'(busy), e_busy);
      check_eq("done", int'(done), e_done);
      check_eq("err", int'(err), e_err);

      start = s; op = o; src = sr; sa_in = sa;
      if (active && (cur == ks + 1)) begin
         m_n     = int'(sa);
         exp_amt = int'(sa);
      end
      busy_now = active && ((cur - ks <= 2) || (cur - ks <= 3 + m_n));
      if (s && !busy_now) begin
         if (o == 2'b11) begin
            err_at = cur + 1;
         end else begin
            active = 1'b1;
            ks     = cur;
            m_n    = 31;
            m_op   = o;
            m_src  = sr;
         end
      end
      cur++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 2'($urandom), 2'($urandom), 5'($urandom));
      end
   endtask

   task automatic xfer(input logic [1:0] o, input logic [1:0] sr, input logic [4:0] sa);
      step(1'b1, o, sr, 5'($urandom));
      step(1'b0, 2'($urandom), 2'($urandom), sa);
   endtask

   task automatic do_reset();
      start   = 1'b0;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      active  = 1'b0;
      err_at  = -1;
      exp_amt = 0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      cur += 2;
   endtask

   initial begin
      n_checks = 0; n_fails = 0;
      cur = 0; ks = 0; m_n = 0; err_at = -1; active = 1'b0;
      m_op = 2'b00; m_src = 2'b00; exp_amt = 0;
      start = 1'b0; op = 2'b00; src = 2'b00; sa_in = 5'd0;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      idle(2);
      xfer(2'b00, 2'b00, 5'd3);
      idle(6);
      xfer(2'b00, 2'b00, 5'd5);
      idle(3);
      do_reset();
      idle(10);
      xfer(2'b10, 2'b01, 5'd0);
      idle(4);
      xfer(2'b01, 2'b10, 5'd16);
      idle(20);
      xfer(2'b01, 2'b11, 5'd31);
      idle(35);
      step(1'b1, 2'b11, 2'b00, 5'd0);
      idle(2);
      xfer(2'b00, 2'b01, 5'd5);
      idle(2);
      step(1'b1, 2'b01, 2'b10, 5'd7);
      idle(8);
      // Back-to-back: start on the DONE cycle is dropped, the next one is taken
      xfer(2'b10, 2'b11, 5'd2);
      idle(3);
      step(1'b1, 2'b00, 2'b01, 5'd0);
      xfer(2'b01, 2'b10, 5'd4);
      idle(10);

      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 3) == 0), 2'($urandom), 2'($urandom), 5'($urandom_range(0, 31)));
      end
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
